muldiv_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 23 ++
 rtl/muldiv_divider.sv | 75 +++++++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the execute-stage multiply/divide unit.
// funct3 encodings, FSM state type and operand width.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring divider on operand magnitudes, one quotient bit per cycle.
// Flags divide-by-zero and signed overflow so the caller can finish early.
module muldiv_divider
  import riscv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic            o_dz,
  output logic            o_ov,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);

  logic            busy_q;
  logic            ov_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] q_q;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] d_q;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            ov_d;
  logic [XLEN:0]   shl;
  logic [XLEN:0]   diff;

  assign a_mag = (i_signed && i_a[XLEN-1]) ? -i_a : i_a;
  assign b_mag = (i_signed && i_b[XLEN-1]) ? -i_b : i_b;
  assign ov_d  = i_signed
              && (i_a == {1'b1, {(XLEN-1){1'b0}}})
              && (i_b == {XLEN{1'b1}});

  // diff[XLEN] set means the trial subtraction borrowed
  assign shl  = {r_q, q_q[XLEN-1]};
  assign diff = shl - {1'b0, d_q};

  assign o_dz   = (d_q == '0);
  assign o_ov   = ov_q;
  assign o_quot = {q_q[XLEN-2:0], ~diff[XLEN]};
  assign o_rem  = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
  assign o_done = busy_q
               && ((cnt_q == 5'd31)
               || ((cnt_q == 5'd0) && (o_dz || o_ov)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      busy_q <= 1'b0;
      ov_q   <= 1'b0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
    end else if (i_flush) begin
      busy_q <= 1'b0;
    end else if (i_start) begin
      busy_q <= 1'b1;
      ov_q   <= ov_d;
      cnt_q  <= '0;
      q_q    <= a_mag;
      r_q    <= '0;
      d_q    <= b_mag;
    end else if (busy_q) begin
      q_q   <= o_quot;
      r_q   <= o_rem;
      cnt_q <= cnt_q + 5'd1;
      if (o_done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit with accept/complete handshake.
// MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
module muldiv_unit
  import riscv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren
);

  muldiv_state_t     state_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q, acc_d, prod;
  logic              valid_q;
  logic [4:0]        addr_q;
  logic [XLEN-1:0]   data_q;
`ifndef MULDIV_FAST_MUL_EN
  logic [4:0]        cnt_q;
  logic [XLEN:0]     sum;
`endif

  logic            sa_in, sb_in, mul_done;
  logic [XLEN-1:0] a_mag, b_mag, mul_res;
  logic            dv_done, dv_dz, dv_ov;
  logic [XLEN-1:0] dv_q, dv_r, quot, rem, div_res;
  logic            accept;

  assign accept = (state_q == IDLE) && i_valid;

  // MUL low bits are sign-agnostic, so it shares the signed path
  assign sa_in = i_rs1_data[XLEN-1]
              & (i_funct3[2] ? ~i_funct3[0] : (i_funct3 != F3_MULHU));
  assign sb_in = i_rs2_data[XLEN-1]
              & (i_funct3[2] ? ~i_funct3[0] : ~i_funct3[1]);
  assign a_mag = sa_in ? -i_rs1_data : i_rs1_data;
  assign b_mag = sb_in ? -i_rs2_data : i_rs2_data;

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    acc_d    = {{XLEN{1'b0}}, mcand_q} * acc_q;
    mul_done = 1'b1;
`else
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]}
             + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d    = {sum, acc_q[XLEN-1:1]};
    mul_done = (cnt_q == 5'd31);
`endif
    prod    = (sa_q ^ sb_q) ? -acc_d : acc_d;
    mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0]
                               : prod[2*XLEN-1:XLEN];
  end

  muldiv_divider u_div (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_flush  (i_flush),
    .i_start  (accept && i_funct3[2]),
    .i_signed (~i_funct3[0]),
    .i_a      (i_rs1_data),
    .i_b      (i_rs2_data),
    .o_done   (dv_done),
    .o_dz     (dv_dz),
    .o_ov     (dv_ov),
    .o_quot   (dv_q),
    .o_rem    (dv_r)
  );

  always_comb begin
    quot = (sa_q ^ sb_q) ? -dv_q : dv_q;
    rem  = sa_q ? -dv_r : dv_r;
    if (dv_dz) begin
      quot = {XLEN{1'b1}};
      rem  = a_q;
    end else if (dv_ov) begin
      quot = {1'b1, {(XLEN-1){1'b0}}};
      rem  = '0;
    end
    div_res = f3_q[1] ? rem : quot;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      f3_q    <= '0;
      rd_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifndef MULDIV_FAST_MUL_EN
      cnt_q   <= '0;
`endif
    end else if (i_flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (i_valid) begin
          state_q <= i_funct3[2] ? DIV : MUL;
          f3_q    <= i_funct3;
          rd_q    <= i_rd_addr;
          sa_q    <= sa_in;
          sb_q    <= sb_in;
          a_q     <= i_rs1_data;
          mcand_q <= a_mag;
          acc_q   <= {{XLEN{1'b0}}, b_mag};
`ifndef MULDIV_FAST_MUL_EN
          cnt_q   <= '0;
`endif
        end
        MUL: begin
          acc_q <= acc_d;
`ifndef MULDIV_FAST_MUL_EN
          cnt_q <= cnt_q + 5'd1;
`endif
          if (mul_done) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            addr_q  <= rd_q;
            data_q  <= mul_res;
          end
        end
        DIV: if (dv_done) begin
          state_q <= DONE;
          valid_q <= 1'b1;
          addr_q  <= rd_q;
          data_q  <= div_res;
        end
        DONE: if (i_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = valid_q;
  assign o_rd_addr = addr_q;
  assign o_rd_data = data_q;
  assign o_rd_wren = valid_q && (addr_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, stall, flush, reset.
// Latencies follow MULDIV_FAST_MUL_EN when defined.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, vin, rdy_in;
  logic        rdy_out, vout, wren;
  logic [2:0]  f3;
  logic [31:0] a, b, data;
  logic [4:0]  rd, addr;
  int ncmp = 0;
  int nerr = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 32;
`endif

  always #5 clk = ~clk;

  muldiv_unit dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_flush    (flush),
    .i_valid    (vin),
    .o_ready    (rdy_out),
    .i_funct3   (f3),
    .i_rs1_data (a),
    .i_rs2_data (b),
    .i_rd_addr  (rd),
    .o_valid    (vout),
    .i_ready    (rdy_in),
    .o_rd_addr  (addr),
    .o_rd_data  (data),
    .o_rd_wren  (wren)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string tag, input logic [2:0] fn,
                    input logic [31:0] x, input logic [31:0] y,
                    input logic [4:0] r, input logic [31:0] exp,
                    input int lat, input int hold);
    int n;
    logic [31:0] d0;
    f3 = fn; a = x; b = y; rd = r; vin = 1'b1;
    tick();
    vin = 1'b0;
    a = 32'h1234_5678; b = 32'h0000_0003; rd = 5'd9;
    n = 0;
    while (!vout && n < 100) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".data"}, data, exp);
    chk({tag, ".addr"}, {27'b0, addr}, {27'b0, r});
    chk({tag, ".wren"}, {31'b0, wren}, {31'b0, r != 5'd0});
    d0 = data;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, ".hold_v"}, {31'b0, vout}, 32'd1);
      chk({tag, ".hold_d"}, data, d0);
      chk({tag, ".hold_rdy"}, {31'b0, rdy_out}, 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    chk({tag, ".idle_rdy"}, {31'b0, rdy_out}, 32'd1);
    chk({tag, ".idle_v"}, {31'b0, vout}, 32'd0);
  endtask

  task automatic no_valid(input string tag, input int cyc);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cyc; k++) begin
      tick();
      if (vout) seen = 1'b1;
    end
    chk(tag, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; vin = 1'b0; rdy_in = 1'b0;
    f3 = '0; a = '0; b = '0; rd = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.ready", {31'b0, rdy_out}, 32'd1);
    chk("rst.valid", {31'b0, vout}, 32'd0);
    chk("rst.wren", {31'b0, wren}, 32'd0);
    chk("rst.addr", {27'b0, addr}, 32'd0);
    chk("rst.data", data, 32'd0);

    op("mul", 3'b000, 32'h7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MLAT, 0);
    op("mulh", 3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,
       32'h0000_0000, MLAT, 0);
    op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,
       32'h8000_0000, MLAT, 0);
    op("mulhu", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,
       32'h7FFF_FFFF, MLAT, 0);
    op("div", 3'b100, 32'hFFFF_FFF9, 32'h2, 5'd10, 32'hFFFF_FFFD, 32, 0);
    op("rem", 3'b110, 32'hFFFF_FFF9, 32'h2, 5'd11, 32'hFFFF_FFFF, 32, 0);
    op("divu", 3'b101, 32'hFFFF_FFFF, 32'h2, 5'd12, 32'h7FFF_FFFF, 32, 0);
    op("remu0", 3'b111, 32'h7, 32'h0, 5'd13, 32'h7, 1, 0);
    op("div0", 3'b100, 32'h1234, 32'h0, 5'd14, 32'hFFFF_FFFF, 1, 0);
    op("divov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15,
       32'h8000_0000, 1, 0);
    op("remov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16,
       32'h0, 1, 0);
    op("stall", 3'b101, 32'd100, 32'd7, 5'd17, 32'd14, 32, 5);
    op("rd0", 3'b000, 32'd2, 32'd3, 5'd0, 32'd6, MLAT, 0);

    // flush during cycle T+10 of a divide
    f3 = 3'b100; a = 32'd100; b = 32'd3; rd = 5'd3; vin = 1'b1;
    tick();
    vin = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush.ready", {31'b0, rdy_out}, 32'd1);
    chk("flush.valid", {31'b0, vout}, 32'd0);
    no_valid("flush.never_valid", 40);

    // flush coincident with an accept drops the request
    f3 = 3'b000; a = 32'd5; b = 32'd5; rd = 5'd4;
    vin = 1'b1; flush = 1'b1;
    tick();
    vin = 1'b0; flush = 1'b0;
    chk("flushacc.ready", {31'b0, rdy_out}, 32'd1);
    no_valid("flushacc.never_valid", 40);

    // reset during cycle T+5 of a multiply
    f3 = 3'b000; a = 32'd9; b = 32'd9; rd = 5'd2; vin = 1'b1;
    tick();
    vin = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.ready", {31'b0, rdy_out}, 32'd1);
    chk("midrst.valid", {31'b0, vout}, 32'd0);
    chk("midrst.wren", {31'b0, wren}, 32'd0);
    chk("midrst.addr", {27'b0, addr}, 32'd0);
    chk("midrst.data", data, 32'd0);
    no_valid("midrst.never_valid", 40);

    op("after", 3'b101, 32'd45, 32'd9, 5'd31, 32'd5, 32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
